// File: rtl/hw_barrier_pkg.sv
// Shared types, width helpers and error-cause indices for the hardware barrier array.
package hw_barrier_pkg;

    // Largest core count the stored configuration record can describe.
    localparam int MAX_CORES = 32;

    function automatic int calc_cnt_w(input int num_cores);
        return $clog2(num_cores) + 1;
    endfunction

    function automatic int calc_id_w(input int num_barriers);
        return (num_barriers > 1) ? $clog2(num_barriers) : 1;
    endfunction

    localparam int MAX_CNT_W = calc_cnt_w(MAX_CORES);

    typedef struct packed {
        logic [MAX_CNT_W-1:0] num_threads;
        logic [MAX_CORES-1:0] mask;
    } barrier_cfg_t;

    localparam int ERR_OVERFLOW   = 0;
    localparam int ERR_DISABLED   = 1;
    localparam int ERR_TIMEOUT    = 2;
    localparam int NUM_ERR_CAUSES = 3;

endpackage

// File: rtl/hw_barrier_slot.sv
// State for one barrier: arrival counter, team config, generation bit, sticky error.
// Optional stall timeout enabled by defining HW_BARRIER_TIMEOUT_EN.
module hw_barrier_slot
    import hw_barrier_pkg::*;
#(
    parameter int NUM_CORES  = 8,
    parameter int TIMEOUT_W  = 16,
    localparam int CNT_W     = calc_cnt_w(NUM_CORES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_W-1:0]     arrive_cnt,
    input  logic                 clear,
    input  logic                 cfg_we,
    input  logic [CNT_W-1:0]     cfg_num_threads,
    input  logic [NUM_CORES-1:0] cfg_mask,
    input  logic                 err_clr,
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    output logic [CNT_W-1:0]     counter,
    output logic                 gen,
    output logic                 err,
    output logic                 fire,
    output logic [NUM_CORES-1:0] fire_mask
);

    logic [CNT_W-1:0]          counter_reg, counter_next;
    barrier_cfg_t              cfg_reg, cfg_next;
    logic                      gen_reg, gen_next;
    logic                      err_reg, err_next;
    logic [NUM_ERR_CAUSES-1:0] cause;
    logic [CNT_W:0]            sum;
    logic [MAX_CNT_W:0]        sum_ext, thr_ext;
    logic                      tmo_hit;
    logic                      unused_mask_bits;

    assign sum     = {1'b0, counter_reg} + {1'b0, arrive_cnt};
    assign sum_ext = (MAX_CNT_W+1)'(sum);
    assign thr_ext = {1'b0, cfg_reg.num_threads};

    always_comb begin
        counter_next = counter_reg;
        cfg_next     = cfg_reg;
        gen_next     = gen_reg;
        fire         = 1'b0;
        cause        = '0;
        cause[ERR_TIMEOUT] = tmo_hit;
        if (clear) begin
            counter_next = '0;
        end else if (cfg_we) begin
            cfg_next.num_threads = MAX_CNT_W'(cfg_num_threads);
            cfg_next.mask        = MAX_CORES'(cfg_mask);
            counter_next         = '0;
        end else if (arrive_cnt != '0) begin
            if (thr_ext == '0) begin
                cause[ERR_DISABLED] = 1'b1;
            end else if (sum_ext < thr_ext) begin
                counter_next = sum[CNT_W-1:0];
            end else begin
                // Surplus arrivals are flagged and dropped, never carried into the next round.
                fire                = 1'b1;
                counter_next        = '0;
                gen_next            = ~gen_reg;
                cause[ERR_OVERFLOW] = (sum_ext > thr_ext);
            end
        end
        err_next = (err_reg & ~err_clr) | (|cause);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter_reg <= '0;
            cfg_reg     <= '0;
            gen_reg     <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            counter_reg <= counter_next;
            cfg_reg     <= cfg_next;
            gen_reg     <= gen_next;
            err_reg     <= err_next;
        end
    end

`ifdef HW_BARRIER_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_reg, tmo_next;

    // Counts idle cycles of a partially filled barrier; saturates at the limit.
    always_comb begin
        tmo_next = tmo_reg;
        tmo_hit  = 1'b0;
        if (clear || cfg_we || (arrive_cnt != '0)) begin
            tmo_next = '0;
        end else if ((counter_reg != '0) && (timeout_limit != '0) && (tmo_reg < timeout_limit)) begin
            tmo_next = tmo_reg + TIMEOUT_W'(1);
            tmo_hit  = (tmo_next == timeout_limit);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_reg <= '0;
        end else begin
            tmo_reg <= tmo_next;
        end
    end
`else
    logic unused_timeout_limit;
    assign tmo_hit              = 1'b0;
    assign unused_timeout_limit = ^timeout_limit;
`endif

    assign unused_mask_bits = ^(cfg_reg.mask >> NUM_CORES);

    assign counter   = counter_reg;
    assign gen       = gen_reg;
    assign err       = err_reg;
    assign fire_mask = cfg_reg.mask[NUM_CORES-1:0];

endmodule

// File: rtl/hw_barrier_array.sv
// Multi-barrier synchronisation unit: per-barrier arrival popcount, slot array, registered wake-up events.
// Define HW_BARRIER_TIMEOUT_EN to build the per-barrier stall timeout into each slot.
module hw_barrier_array
    import hw_barrier_pkg::*;
#(
    parameter int NUM_CORES    = 8,
    parameter int NUM_BARRIERS = 8,
    parameter int TIMEOUT_W    = 16,
    localparam int CNT_W       = calc_cnt_w(NUM_CORES),
    localparam int ID_W        = calc_id_w(NUM_BARRIERS)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_CORES-1:0]          arrive_i,
    input  logic [NUM_CORES*ID_W-1:0]     arrive_id_i,
    input  logic                          cfg_valid_i,
    input  logic [ID_W-1:0]               cfg_id_i,
    input  logic [CNT_W-1:0]              cfg_num_threads_i,
    input  logic [NUM_CORES-1:0]          cfg_mask_i,
    input  logic [NUM_BARRIERS-1:0]       clear_i,
    input  logic [TIMEOUT_W-1:0]          timeout_limit_i,
    output logic [NUM_CORES-1:0]          barrier_event_o,
    output logic [NUM_BARRIERS*CNT_W-1:0] barrier_counter_o,
    output logic [NUM_BARRIERS-1:0]       barrier_gen_o,
    output logic [NUM_BARRIERS-1:0]       barrier_err_o,
    input  logic [NUM_BARRIERS-1:0]       err_clr_i
);

    logic [NUM_CORES-1:0]    event_reg, event_next;
    logic [NUM_BARRIERS-1:0] fire;
    logic [NUM_CORES-1:0]    fire_mask [NUM_BARRIERS];

    generate
        for (genvar gi = 0; gi < NUM_BARRIERS; gi++) begin : g_slot
            logic [CNT_W-1:0] arrive_cnt;
            logic             cfg_we;

            // IDs beyond NUM_BARRIERS never match any slot and are silently ignored.
            always_comb begin
                arrive_cnt = '0;
                for (int c = 0; c < NUM_CORES; c++) begin
                    if (arrive_i[c] && (arrive_id_i[c*ID_W +: ID_W] == ID_W'(gi))) begin
                        arrive_cnt = arrive_cnt + CNT_W'(1);
                    end
                end
            end

            assign cfg_we = cfg_valid_i && (cfg_id_i == ID_W'(gi));

            hw_barrier_slot #(
                .NUM_CORES (NUM_CORES),
                .TIMEOUT_W (TIMEOUT_W)
            ) u_slot (
                .clk             (clk_i),
                .rst             (rst_i),
                .arrive_cnt      (arrive_cnt),
                .clear           (clear_i[gi]),
                .cfg_we          (cfg_we),
                .cfg_num_threads (cfg_num_threads_i),
                .cfg_mask        (cfg_mask_i),
                .err_clr         (err_clr_i[gi]),
                .timeout_limit   (timeout_limit_i),
                .counter         (barrier_counter_o[gi*CNT_W +: CNT_W]),
                .gen             (barrier_gen_o[gi]),
                .err             (barrier_err_o[gi]),
                .fire            (fire[gi]),
                .fire_mask       (fire_mask[gi])
            );
        end
    endgenerate

    // Simultaneous releases merge into a single pulse per core.
    always_comb begin
        event_next = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            if (fire[b]) begin
                event_next = event_next | fire_mask[b];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            event_reg <= '0;
        end else begin
            event_reg <= event_next;
        end
    end

    assign barrier_event_o = event_reg;

endmodule

// File: tb/tb_hw_barrier_array.sv
// Directed bench for hw_barrier_array (8 cores, 8 barriers) with a scoreboard queue of expected wake-up events.
module tb_hw_barrier_array;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  arrive;
    logic [23:0] arrive_id;
    logic        cfg_valid;
    logic [2:0]  cfg_id;
    logic [3:0]  cfg_nt;
    logic [7:0]  cfg_mask;
    logic [7:0]  clear;
    logic [15:0] tlimit;
    logic [7:0]  ev;
    logic [31:0] cnt;
    logic [7:0]  gen;
    logic [7:0]  err;
    logic [7:0]  err_clr;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  ev_q [$];
    logic [7:0]  ev_exp;

    hw_barrier_array #(
        .NUM_CORES    (8),
        .NUM_BARRIERS (8),
        .TIMEOUT_W    (16)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .arrive_i          (arrive),
        .arrive_id_i       (arrive_id),
        .cfg_valid_i       (cfg_valid),
        .cfg_id_i          (cfg_id),
        .cfg_num_threads_i (cfg_nt),
        .cfg_mask_i        (cfg_mask),
        .clear_i           (clear),
        .timeout_limit_i   (tlimit),
        .barrier_event_o   (ev),
        .barrier_counter_o (cnt),
        .barrier_gen_o     (gen),
        .barrier_err_o     (err),
        .err_clr_i         (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every cycle pops the event expected from the stimulus applied before the last edge.
    always @(negedge clk) begin
        ev_exp = (ev_q.size() > 0) ? ev_q.pop_front() : 8'h00;
        check("event", 32'(ev), 32'(ev_exp));
    end

    function automatic logic [3:0] cnt_of(input int b);
        return cnt[b*4 +: 4];
    endfunction

    task automatic cycle(input logic [7:0] exp_ev);
        ev_q.push_back(exp_ev);
        @(posedge clk);
        @(negedge clk);
        #1;
        arrive    = '0;
        arrive_id = '0;
        cfg_valid = 1'b0;
        clear     = '0;
        err_clr   = '0;
    endtask

    task automatic arr(input int core, input int id);
        arrive[core]            = 1'b1;
        arrive_id[core*3 +: 3]  = 3'(id);
    endtask

    task automatic cfg(input int id, input int nt, input logic [7:0] mask);
        cfg_valid = 1'b1;
        cfg_id    = 3'(id);
        cfg_nt    = 4'(nt);
        cfg_mask  = mask;
        cycle(8'h00);
    endtask

    initial begin
        rst = 1'b1; arrive = '0; arrive_id = '0; cfg_valid = 1'b0; cfg_id = '0;
        cfg_nt = '0; cfg_mask = '0; clear = '0; err_clr = '0; tlimit = 16'd20;
        cycle(8'h00);
        cycle(8'h00);
        rst = 1'b0;
        check("rst_counters", cnt, 32'h0);
        check("rst_gen", 32'(gen), 32'h0);
        check("rst_err", 32'(err), 32'h0);

        cfg(0, 4, 8'h0F);
        cfg(2, 8, 8'hFF);
        cfg(1, 2, 8'h18);
        cfg(3, 2, 8'h30);

        // Barrier 0: four arrivals on separate cycles.
        for (int i = 0; i < 3; i++) begin
            arr(i, 0);
            cycle(8'h00);
            check("b0_count", 32'(cnt_of(0)), 32'(i + 1));
        end
        arr(3, 0);
        cycle(8'h0F);
        check("b0_count_release", 32'(cnt_of(0)), 32'h0);
        check("b0_gen", 32'(gen[0]), 32'h1);
        check("b0_err", 32'(err[0]), 32'h0);
        cycle(8'h00);

        // Barrier 2: all cores in one cycle, then back-to-back again.
        for (int c = 0; c < 8; c++) arr(c, 2);
        cycle(8'hFF);
        check("b2_err", 32'(err[2]), 32'h0);
        check("b2_gen", 32'(gen[2]), 32'h1);
        check("b2_count", 32'(cnt_of(2)), 32'h0);
        for (int c = 0; c < 8; c++) arr(c, 2);
        cycle(8'hFF);
        check("b2_gen_b2b", 32'(gen[2]), 32'h0);

        // Barrier 1 overflow and error clear.
        arr(0, 1);
        cycle(8'h00);
        check("b1_count", 32'(cnt_of(1)), 32'h1);
        arr(3, 1); arr(4, 1);
        cycle(8'h18);
        check("b1_overflow_err", 32'(err[1]), 32'h1);
        check("b1_count_release", 32'(cnt_of(1)), 32'h0);
        check("b1_gen", 32'(gen[1]), 32'h1);
        err_clr = 8'h02;
        cycle(8'h00);
        check("b1_err_clr", 32'(err[1]), 32'h0);

        // Barrier 3: clear beats a completing arrival.
        arr(5, 3);
        cycle(8'h00);
        check("b3_count", 32'(cnt_of(3)), 32'h1);
        arr(6, 3); clear = 8'h08;
        cycle(8'h00);
        check("b3_clear_count", 32'(cnt_of(3)), 32'h0);
        check("b3_clear_gen", 32'(gen[3]), 32'h0);

        // Barrier 5 unconfigured; set wins over simultaneous clear.
        arr(2, 5);
        cycle(8'h00);
        check("b5_disabled_err", 32'(err[5]), 32'h1);
        check("b5_count", 32'(cnt_of(5)), 32'h0);
        arr(2, 5); err_clr = 8'h20;
        cycle(8'h00);
        check("b5_set_wins", 32'(err[5]), 32'h1);
        err_clr = 8'h20;
        cycle(8'h00);
        check("b5_err_clr", 32'(err[5]), 32'h0);

        // Barriers 0 and 1 release together: one merged pulse.
        for (int c = 0; c < 4; c++) arr(c, 0);
        arr(4, 1); arr(5, 1);
        cycle(8'h1F);
        check("merge_b1_err", 32'(err[1]), 32'h0);
        check("merge_gen", 32'(gen[1:0]), 32'h0);

        // Config write drops same-cycle arrival; new config applies next cycle.
        cfg_valid = 1'b1; cfg_id = 3'd0; cfg_nt = 4'd1; cfg_mask = 8'h01;
        arr(0, 0);
        cycle(8'h00);
        check("cfg_drop_count", 32'(cnt_of(0)), 32'h0);
        arr(0, 0);
        cycle(8'h01);
        check("cfg_new_gen", 32'(gen[0]), 32'h1);

        // Reset in the middle of a count suppresses the pending release.
        arr(0, 2); arr(1, 2); arr(2, 2); arr(6, 5);
        cycle(8'h00);
        check("b2_pre_rst_count", 32'(cnt_of(2)), 32'h3);
        check("b5_pre_rst_err", 32'(err[5]), 32'h1);
        rst = 1'b1;
        for (int c = 3; c < 8; c++) arr(c, 2);
        cycle(8'h00);
        rst = 1'b0;
        check("mid_rst_counters", cnt, 32'h0);
        check("mid_rst_gen", 32'(gen), 32'h0);
        check("mid_rst_err", 32'(err), 32'h0);
        arr(0, 2);
        cycle(8'h00);
        check("post_rst_cfg_cleared", 32'(err[2]), 32'h1);

        // Stall timeout on barrier 4 (limit 20).
        cfg(4, 3, 8'h40);
        arr(1, 4);
        cycle(8'h00);
        check("b4_count", 32'(cnt_of(4)), 32'h1);
        for (int i = 0; i < 19; i++) cycle(8'h00);
        check("b4_err_before_limit", 32'(err[4]), 32'h0);
        cycle(8'h00);
`ifdef HW_BARRIER_TIMEOUT_EN
        check("b4_timeout_err", 32'(err[4]), 32'h1);
`else
        check("b4_no_timeout_err", 32'(err[4]), 32'h0);
`endif
        check("b4_count_held", 32'(cnt_of(4)), 32'h1);

        check("ev_queue_drained", 32'(ev_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
